// File: rtl/alu_share_ctrl.sv
// Two-requester round-robin sequencer for a shared combinational ALU.
// Registers operands and response, and owns the architectural NZCV flags.
module alu_share_ctrl #(
  parameter int unsigned DATA_W    = 32,
  parameter logic [3:0]  FLAGS_RST = 4'b0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [3:0]        req_cmd0,
  input  logic [3:0]        req_cmd1,
  input  logic [DATA_W-1:0] req_a0,
  input  logic [DATA_W-1:0] req_a1,
  input  logic [DATA_W-1:0] req_b0,
  input  logic [DATA_W-1:0] req_b1,
  input  logic [1:0]        req_s,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic [3:0]        rsp_status,
  output logic [3:0]        flags,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [3:0]        alu_exe_cmd,
  output logic              alu_carry_in,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [3:0]        alu_status,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e            state_q;
  logic [3:0]        flags_q;
  logic [1:0]        rsp_valid_q;
  logic [DATA_W-1:0] rsp_result_q;
  logic [3:0]        rsp_status_q;
  logic [3:0]        cmd_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic              s_q;
  logic              win_q;
  logic              last_grant_q;

  logic              win_d;
  logic              any_valid;
  logic [3:0]        cmd_d;
  logic [DATA_W-1:0] a_d;
  logic [DATA_W-1:0] b_d;
  logic              s_d;

  // On a tie the requester that was not granted last time wins.
  always_comb begin
    win_d = 1'b0;
    case (req_valid)
      2'b01:   win_d = 1'b0;
      2'b10:   win_d = 1'b1;
      2'b11:   win_d = ~last_grant_q;
      default: win_d = 1'b0;
    endcase
    any_valid = |req_valid;
    cmd_d     = win_d ? req_cmd1 : req_cmd0;
    a_d       = win_d ? req_a1   : req_a0;
    b_d       = win_d ? req_b1   : req_b0;
    s_d       = req_s[win_d];
  end

  always_comb begin
    req_ready = '0;
    if (rst && (state_q == IDLE) && any_valid) begin
      req_ready[win_d] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      flags_q      <= FLAGS_RST;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_status_q <= '0;
      cmd_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      s_q          <= 1'b0;
      win_q        <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_valid) begin
            cmd_q        <= cmd_d;
            a_q          <= a_d;
            b_q          <= b_d;
            s_q          <= s_d;
            win_q        <= win_d;
            last_grant_q <= win_d;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          rsp_result_q <= alu_result;
          rsp_status_q <= alu_status;
          if (s_q) begin
            flags_q <= alu_status;
          end
          rsp_valid_q <= win_q ? 2'b10 : 2'b01;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready[win_q]) begin
            rsp_valid_q <= '0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_status   = rsp_status_q;
  assign flags        = flags_q;
  assign alu_in1      = a_q;
  assign alu_in2      = b_q;
  assign alu_exe_cmd  = cmd_q;
  assign alu_carry_in = flags_q[1];
  assign busy         = (state_q != IDLE);

endmodule
